// File: rtl/memory_stage_if.sv
// Data-memory request/acknowledge bus between the memory stage and data memory.
interface memory_stage_if;
    logic        dmem_req;
    logic        dmem_we;
    logic [15:0] dmem_addr;
    logic [15:0] dmem_wdata;
    logic [15:0] dmem_rdata;
    logic        dmem_ack;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_wdata,
        input  dmem_rdata, dmem_ack
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
        output dmem_rdata, dmem_ack
    );
endinterface

// File: rtl/memory_stage.sv
// Memory-access pipeline stage: runs load/store transactions with timeout,
// resolves branches and presents registered write-back results.
module memory_stage #(
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        valid_in,
    input  logic [15:0] alu_result_in,
    input  logic        zero_in,
    input  logic [15:0] write_data_in,
    input  logic [2:0]  dest_reg_in,
    input  logic        mem_read_in,
    input  logic        mem_write_in,
    input  logic        reg_write_in,
    input  logic        branch_in,
    input  logic [15:0] branch_target_in,
    output logic        stall_out,
    memory_stage_if.master dmem,
    output logic        wb_valid,
    output logic        wb_reg_write,
    output logic [2:0]  wb_dest_reg,
    output logic [15:0] wb_data,
    output logic        pc_src,
    output logic [15:0] branch_target_out,
    output logic        mem_error
);

    localparam int unsigned DW = 16;
    localparam int unsigned RW = 3;
    localparam int unsigned CW = 8;

    localparam logic [0:0] IDLE   = 1'b0;
    localparam logic [0:0] ACCESS = 1'b1;

    // Counter value reached in the last allowed ACCESS cycle.
    localparam logic [CW-1:0] TMO_LAST = CW'(MEM_TIMEOUT - 1);

    logic [0:0]    state, state_d;
    logic [CW-1:0] cnt, cnt_d;
    logic [RW-1:0] lat_dest, lat_dest_d;
    logic          lat_rw, lat_rw_d;

    logic          req_d, we_d;
    logic [DW-1:0] addr_d, wdata_d;
    logic          stall_d;
    logic          wb_valid_d, wb_rw_d;
    logic [RW-1:0] wb_dest_d;
    logic [DW-1:0] wb_data_d;
    logic          pc_src_d;
    logic [DW-1:0] tgt_d;
    logic          err_d;

    // Next-state and next-output decode.
    always_comb begin
        state_d    = state;
        cnt_d      = cnt;
        lat_dest_d = lat_dest;
        lat_rw_d   = lat_rw;
        req_d      = dmem.dmem_req;
        we_d       = dmem.dmem_we;
        addr_d     = dmem.dmem_addr;
        wdata_d    = dmem.dmem_wdata;
        wb_valid_d = 1'b0;
        wb_rw_d    = wb_reg_write;
        wb_dest_d  = wb_dest_reg;
        wb_data_d  = wb_data;
        pc_src_d   = 1'b0;
        tgt_d      = branch_target_out;
        err_d      = mem_error;

        case (state)
            IDLE: begin
                if (valid_in) begin
                    pc_src_d = branch_in & zero_in;
                    tgt_d    = branch_target_in;
                    if (mem_read_in || mem_write_in) begin
                        state_d    = ACCESS;
                        cnt_d      = '0;
                        req_d      = 1'b1;
                        // A combined read+write is treated as a load.
                        we_d       = mem_write_in & ~mem_read_in;
                        addr_d     = alu_result_in;
                        wdata_d    = write_data_in;
                        lat_dest_d = dest_reg_in;
                        lat_rw_d   = reg_write_in;
                    end else begin
                        wb_valid_d = 1'b1;
                        wb_rw_d    = reg_write_in;
                        wb_dest_d  = dest_reg_in;
                        wb_data_d  = alu_result_in;
                    end
                end
            end
            ACCESS: begin
                if (dmem.dmem_ack) begin
                    state_d    = IDLE;
                    req_d      = 1'b0;
                    wb_valid_d = 1'b1;
                    wb_dest_d  = lat_dest;
                    if (dmem.dmem_we) begin
                        wb_data_d = dmem.dmem_addr;
                        wb_rw_d   = 1'b0;
                    end else begin
                        wb_data_d = dmem.dmem_rdata;
                        wb_rw_d   = lat_rw;
                    end
                end else if (cnt == TMO_LAST) begin
                    state_d    = IDLE;
                    req_d      = 1'b0;
                    wb_valid_d = 1'b1;
                    wb_rw_d    = 1'b0;
                    wb_dest_d  = lat_dest;
                    err_d      = 1'b1;
                end else begin
                    cnt_d = cnt + CW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                req_d   = 1'b0;
            end
        endcase

        stall_d = (state_d == ACCESS);
    end

    // State, timeout counter and latched transaction attributes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            lat_dest <= '0;
            lat_rw   <= 1'b0;
        end else begin
            state    <= state_d;
            cnt      <= cnt_d;
            lat_dest <= lat_dest_d;
            lat_rw   <= lat_rw_d;
        end
    end

    // Registered outputs toward memory, write-back and fetch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_out         <= 1'b0;
            dmem.dmem_req     <= 1'b0;
            dmem.dmem_we      <= 1'b0;
            dmem.dmem_addr    <= '0;
            dmem.dmem_wdata   <= '0;
            wb_valid          <= 1'b0;
            wb_reg_write      <= 1'b0;
            wb_dest_reg       <= '0;
            wb_data           <= '0;
            pc_src            <= 1'b0;
            branch_target_out <= '0;
            mem_error         <= 1'b0;
        end else begin
            stall_out         <= stall_d;
            dmem.dmem_req     <= req_d;
            dmem.dmem_we      <= we_d;
            dmem.dmem_addr    <= addr_d;
            dmem.dmem_wdata   <= wdata_d;
            wb_valid          <= wb_valid_d;
            wb_reg_write      <= wb_rw_d;
            wb_dest_reg       <= wb_dest_d;
            wb_data           <= wb_data_d;
            pc_src            <= pc_src_d;
            branch_target_out <= tgt_d;
            mem_error         <= err_d;
        end
    end

endmodule

// File: tb/tb_memory_stage.sv
// Self-checking bench for memory_stage with MEM_TIMEOUT=4.
module tb_memory_stage;

    localparam int unsigned TMO = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        valid_in;
    logic [15:0] alu_result_in;
    logic        zero_in;
    logic [15:0] write_data_in;
    logic [2:0]  dest_reg_in;
    logic        mem_read_in, mem_write_in, reg_write_in, branch_in;
    logic [15:0] branch_target_in;
    logic        stall_out;
    logic        wb_valid, wb_reg_write;
    logic [2:0]  wb_dest_reg;
    logic [15:0] wb_data;
    logic        pc_src;
    logic [15:0] branch_target_out;
    logic        mem_error;

    int passed = 0;
    int total  = 0;

    memory_stage_if bus ();

    memory_stage #(.MEM_TIMEOUT(TMO)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .valid_in          (valid_in),
        .alu_result_in     (alu_result_in),
        .zero_in           (zero_in),
        .write_data_in     (write_data_in),
        .dest_reg_in       (dest_reg_in),
        .mem_read_in       (mem_read_in),
        .mem_write_in      (mem_write_in),
        .reg_write_in      (reg_write_in),
        .branch_in         (branch_in),
        .branch_target_in  (branch_target_in),
        .stall_out         (stall_out),
        .dmem              (bus.master),
        .wb_valid          (wb_valid),
        .wb_reg_write      (wb_reg_write),
        .wb_dest_reg       (wb_dest_reg),
        .wb_data           (wb_data),
        .pc_src            (pc_src),
        .branch_target_out (branch_target_out),
        .mem_error         (mem_error)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_instr(input logic v, input logic [15:0] alu, input logic z,
                             input logic [15:0] wd, input logic [2:0] dest,
                             input logic rd, input logic wr, input logic rw,
                             input logic br, input logic [15:0] tgt);
        valid_in         = v;
        alu_result_in    = alu;
        zero_in          = z;
        write_data_in    = wd;
        dest_reg_in      = dest;
        mem_read_in      = rd;
        mem_write_in     = wr;
        reg_write_in     = rw;
        branch_in        = br;
        branch_target_in = tgt;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        bus.dmem_ack = 1'b0;
        bus.dmem_rdata = '0;
        set_instr(0, 16'h0, 0, 16'h0, 3'd0, 0, 0, 0, 0, 16'h0);
        repeat (3) tick;
        total++;
        if ({stall_out, bus.dmem_req, bus.dmem_we, bus.dmem_addr, bus.dmem_wdata, wb_valid,
             wb_reg_write, wb_dest_reg, wb_data, pc_src, branch_target_out, mem_error} !== '0) begin
            $display("FAIL reset_outputs: some output nonzero req=%b stall=%b wb_valid=%b data=%h err=%b",
                     bus.dmem_req, stall_out, wb_valid, wb_data, mem_error);
        end else passed++;
        @(negedge clk);
        rst_n = 1'b1;
        tick;
        total++;
        if ({wb_valid, stall_out, bus.dmem_req, pc_src} !== 4'b0000) begin
            $display("FAIL reset_idle: got %b want 0000", {wb_valid, stall_out, bus.dmem_req, pc_src});
        end else passed++;
    endtask

    task automatic test_alu;
        set_instr(1, 16'h1234, 0, 16'h0, 3'd5, 0, 0, 1, 0, 16'h0);
        tick;
        set_instr(0, 16'h0, 0, 16'h0, 3'd0, 0, 0, 0, 0, 16'h0);
        total++;
        if ({wb_valid, wb_reg_write, wb_dest_reg, wb_data, stall_out} !== {1'b1, 1'b1, 3'd5, 16'h1234, 1'b0}) begin
            $display("FAIL alu_wb: got v=%b rw=%b d=%0d data=%h st=%b want 1 1 5 1234 0",
                     wb_valid, wb_reg_write, wb_dest_reg, wb_data, stall_out);
        end else passed++;
        tick;
        total++;
        if (wb_valid !== 1'b0) begin
            $display("FAIL alu_pulse: wb_valid got %b want 0", wb_valid);
        end else passed++;
    endtask

    task automatic test_back_to_back;
        logic [15:0] vals [3];
        vals[0] = 16'hA001; vals[1] = 16'hB002; vals[2] = 16'hC003;
        for (int i = 0; i < 3; i++) begin
            set_instr(1, vals[i], 0, 16'h0, 3'(i + 1), 0, 0, 1, 0, 16'h0);
            tick;
            total++;
            if ({wb_valid, wb_dest_reg, wb_data} !== {1'b1, 3'(i + 1), vals[i]}) begin
                $display("FAIL b2b_%0d: got v=%b d=%0d data=%h want 1 %0d %h",
                         i, wb_valid, wb_dest_reg, wb_data, i + 1, vals[i]);
            end else passed++;
        end
        set_instr(0, 16'h0, 0, 16'h0, 3'd0, 0, 0, 0, 0, 16'h0);
        tick;
    endtask

    task automatic test_load;
        set_instr(1, 16'h0040, 0, 16'h0, 3'd3, 1, 0, 1, 0, 16'h0);
        tick;
        set_instr(0, 16'h0, 0, 16'h0, 3'd0, 0, 0, 0, 0, 16'h0);
        for (int k = 1; k <= 3; k++) begin
            total++;
            if ({bus.dmem_req, stall_out, bus.dmem_we, bus.dmem_addr, wb_valid} !== {1'b1, 1'b1, 1'b0, 16'h0040, 1'b0}) begin
                $display("FAIL load_req_%0d: got req=%b st=%b we=%b addr=%h wbv=%b want 1 1 0 0040 0",
                         k, bus.dmem_req, stall_out, bus.dmem_we, bus.dmem_addr, wb_valid);
            end else passed++;
            if (k == 3) begin
                bus.dmem_ack = 1'b1;
                bus.dmem_rdata = 16'hBEEF;
            end
            tick;
        end
        bus.dmem_ack = 1'b0;
        total++;
        if ({wb_valid, wb_reg_write, wb_dest_reg, wb_data, bus.dmem_req, stall_out} !==
            {1'b1, 1'b1, 3'd3, 16'hBEEF, 1'b0, 1'b0}) begin
            $display("FAIL load_wb: got v=%b rw=%b d=%0d data=%h req=%b st=%b want 1 1 3 beef 0 0",
                     wb_valid, wb_reg_write, wb_dest_reg, wb_data, bus.dmem_req, stall_out);
        end else passed++;
    endtask

    task automatic test_store;
        set_instr(1, 16'h0010, 0, 16'h00FF, 3'd4, 0, 1, 1, 0, 16'h0);
        tick;
        total++;
        if ({bus.dmem_req, bus.dmem_we, bus.dmem_addr, bus.dmem_wdata} !== {1'b1, 1'b1, 16'h0010, 16'h00FF}) begin
            $display("FAIL store_req: got req=%b we=%b addr=%h wdata=%h want 1 1 0010 00ff",
                     bus.dmem_req, bus.dmem_we, bus.dmem_addr, bus.dmem_wdata);
        end else passed++;
        // upstream holds the next (non-memory) instruction while stalled
        set_instr(1, 16'h5555, 0, 16'h0, 3'd2, 0, 0, 1, 0, 16'h0);
        bus.dmem_ack = 1'b1;
        tick;
        bus.dmem_ack = 1'b0;
        total++;
        if ({wb_valid, wb_reg_write, wb_data, stall_out} !== {1'b1, 1'b0, 16'h0010, 1'b0}) begin
            $display("FAIL store_wb: got v=%b rw=%b data=%h st=%b want 1 0 0010 0",
                     wb_valid, wb_reg_write, wb_data, stall_out);
        end else passed++;
        tick;
        set_instr(0, 16'h0, 0, 16'h0, 3'd0, 0, 0, 0, 0, 16'h0);
        total++;
        if ({wb_valid, wb_reg_write, wb_dest_reg, wb_data} !== {1'b1, 1'b1, 3'd2, 16'h5555}) begin
            $display("FAIL store_next_accept: got v=%b rw=%b d=%0d data=%h want 1 1 2 5555",
                     wb_valid, wb_reg_write, wb_dest_reg, wb_data);
        end else passed++;
        tick;
    endtask

    task automatic test_branch;
        set_instr(1, 16'h0, 1, 16'h0, 3'd0, 0, 0, 0, 1, 16'h0020);
        tick;
        set_instr(0, 16'h0, 0, 16'h0, 3'd0, 0, 0, 0, 0, 16'h0);
        total++;
        if ({pc_src, branch_target_out} !== {1'b1, 16'h0020}) begin
            $display("FAIL branch_taken: got pc_src=%b tgt=%h want 1 0020", pc_src, branch_target_out);
        end else passed++;
        tick;
        total++;
        if ({pc_src, branch_target_out} !== {1'b0, 16'h0020}) begin
            $display("FAIL branch_pulse: got pc_src=%b tgt=%h want 0 0020", pc_src, branch_target_out);
        end else passed++;
        set_instr(1, 16'h1, 0, 16'h0, 3'd0, 0, 0, 0, 1, 16'h0044);
        tick;
        set_instr(0, 16'h0, 0, 16'h0, 3'd0, 0, 0, 0, 0, 16'h0);
        total++;
        if ({pc_src, branch_target_out} !== {1'b0, 16'h0044}) begin
            $display("FAIL branch_not_taken: got pc_src=%b tgt=%h want 0 0044", pc_src, branch_target_out);
        end else passed++;
        tick;
    endtask

    task automatic test_timeout;
        int n;
        set_instr(1, 16'h0080, 0, 16'h0, 3'd6, 1, 0, 1, 0, 16'h0);
        tick;
        set_instr(0, 16'h0, 0, 16'h0, 3'd0, 0, 0, 0, 0, 16'h0);
        n = 0;
        while (bus.dmem_req === 1'b1 && n < 20) begin
            n++;
            tick;
        end
        total++;
        if (n != int'(TMO)) begin
            $display("FAIL timeout_req_cycles: got %0d want %0d", n, TMO);
        end else passed++;
        total++;
        if ({wb_valid, wb_reg_write, mem_error, stall_out} !== 4'b1010) begin
            $display("FAIL timeout_wb: got v=%b rw=%b err=%b st=%b want 1 0 1 0",
                     wb_valid, wb_reg_write, mem_error, stall_out);
        end else passed++;
        // a later successful load leaves the error flag set
        set_instr(1, 16'h0090, 0, 16'h0, 3'd1, 1, 0, 1, 0, 16'h0);
        tick;
        set_instr(0, 16'h0, 0, 16'h0, 3'd0, 0, 0, 0, 0, 16'h0);
        bus.dmem_ack = 1'b1;
        bus.dmem_rdata = 16'h7777;
        tick;
        bus.dmem_ack = 1'b0;
        total++;
        if ({wb_valid, wb_reg_write, wb_data, mem_error} !== {1'b1, 1'b1, 16'h7777, 1'b1}) begin
            $display("FAIL timeout_sticky: got v=%b rw=%b data=%h err=%b want 1 1 7777 1",
                     wb_valid, wb_reg_write, wb_data, mem_error);
        end else passed++;
        tick;
    endtask

    task automatic test_reset_mid_access;
        set_instr(1, 16'h00C0, 0, 16'h0, 3'd2, 1, 0, 1, 0, 16'h0);
        tick;
        set_instr(0, 16'h0, 0, 16'h0, 3'd0, 0, 0, 0, 0, 16'h0);
        tick;
        total++;
        if (bus.dmem_req !== 1'b1) begin
            $display("FAIL rst_mid_pre: req got %b want 1", bus.dmem_req);
        end else passed++;
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if ({bus.dmem_req, stall_out, wb_valid, mem_error} !== 4'b0000) begin
            $display("FAIL rst_mid_async: got req=%b st=%b v=%b err=%b want 0000",
                     bus.dmem_req, stall_out, wb_valid, mem_error);
        end else passed++;
        bus.dmem_ack = 1'b1;
        tick;
        @(negedge clk);
        rst_n = 1'b1;
        tick;
        bus.dmem_ack = 1'b0;
        total++;
        if ({bus.dmem_req, stall_out, wb_valid} !== 3'b000) begin
            $display("FAIL rst_mid_stay: got req=%b st=%b v=%b want 000", bus.dmem_req, stall_out, wb_valid);
        end else passed++;
        set_instr(1, 16'h4321, 0, 16'h0, 3'd7, 0, 0, 1, 0, 16'h0);
        tick;
        set_instr(0, 16'h0, 0, 16'h0, 3'd0, 0, 0, 0, 0, 16'h0);
        total++;
        if ({wb_valid, wb_dest_reg, wb_data} !== {1'b1, 3'd7, 16'h4321}) begin
            $display("FAIL rst_mid_after: got v=%b d=%0d data=%h want 1 7 4321", wb_valid, wb_dest_reg, wb_data);
        end else passed++;
        tick;
    endtask

    // Random instruction stream checked against a transaction-level model.
    task automatic test_random;
        logic        exp_err;
        logic [15:0] alu, wd, tgt, rdv;
        logic [2:0]  dest;
        logic        z, rw, br, rd, wr, is_store, acked, exp_rw;
        logic [15:0] exp_data;
        int          kind, lat;
        exp_err = 1'b0;
        rdv = '0;
        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 2) == 0) begin
                set_instr(0, 16'($urandom), 1, 16'h0, 3'd0, 0, 0, 1, 1, 16'h0);
                bus.dmem_ack = 1'($urandom);
                tick;
                bus.dmem_ack = 1'b0;
                total++;
                if ({wb_valid, pc_src, stall_out, bus.dmem_req} !== 4'b0000) begin
                    $display("FAIL rnd_idle_%0d: got v=%b pc=%b st=%b req=%b want 0000",
                             n, wb_valid, pc_src, stall_out, bus.dmem_req);
                end else passed++;
            end
            kind = int'($urandom_range(0, 3));
            rd   = (kind == 1) || (kind == 3);
            wr   = (kind == 2) || (kind == 3);
            alu  = 16'($urandom);
            wd   = 16'($urandom);
            tgt  = 16'($urandom);
            dest = 3'($urandom);
            z    = 1'($urandom);
            rw   = 1'($urandom);
            br   = 1'($urandom);
            set_instr(1, alu, z, wd, dest, rd, wr, rw, br, tgt);
            tick;
            set_instr(0, 16'h0, 0, 16'h0, 3'd0, 0, 0, 0, 0, 16'h0);
            total++;
            if ({pc_src, branch_target_out} !== {br & z, tgt}) begin
                $display("FAIL rnd_branch_%0d: got pc=%b tgt=%h want %b %h", n, pc_src, branch_target_out, br & z, tgt);
            end else passed++;
            if (!rd && !wr) begin
                total++;
                if ({wb_valid, wb_reg_write, wb_dest_reg, wb_data, stall_out} !== {1'b1, rw, dest, alu, 1'b0}) begin
                    $display("FAIL rnd_alu_%0d: got v=%b rw=%b d=%0d data=%h st=%b want 1 %b %0d %h 0",
                             n, wb_valid, wb_reg_write, wb_dest_reg, wb_data, stall_out, rw, dest, alu);
                end else passed++;
            end else begin
                is_store = wr && !rd;
                lat = int'($urandom_range(1, TMO + 1));
                for (int k = 1; k <= int'(TMO); k++) begin
                    total++;
                    if ({bus.dmem_req, stall_out, bus.dmem_we, bus.dmem_addr, wb_valid} !== {1'b1, 1'b1, is_store, alu, 1'b0}) begin
                        $display("FAIL rnd_req_%0d_%0d: got req=%b st=%b we=%b addr=%h v=%b want 1 1 %b %h 0",
                                 n, k, bus.dmem_req, stall_out, bus.dmem_we, bus.dmem_addr, wb_valid, is_store, alu);
                    end else passed++;
                    if (is_store) begin
                        total++;
                        if (bus.dmem_wdata !== wd) begin
                            $display("FAIL rnd_wdata_%0d: got %h want %h", n, bus.dmem_wdata, wd);
                        end else passed++;
                    end
                    if (k == lat) begin
                        rdv = 16'($urandom);
                        bus.dmem_ack = 1'b1;
                        bus.dmem_rdata = rdv;
                    end
                    tick;
                    bus.dmem_ack = 1'b0;
                    if (k == lat) break;
                end
                acked = (lat <= int'(TMO));
                if (!acked) exp_err = 1'b1;
                exp_rw   = acked && !is_store && rw;
                exp_data = is_store ? alu : rdv;
                total++;
                if ({wb_valid, wb_reg_write, bus.dmem_req, stall_out, mem_error} !== {1'b1, exp_rw, 1'b0, 1'b0, exp_err}) begin
                    $display("FAIL rnd_mem_done_%0d: got v=%b rw=%b req=%b st=%b err=%b want 1 %b 0 0 %b",
                             n, wb_valid, wb_reg_write, bus.dmem_req, stall_out, mem_error, exp_rw, exp_err);
                end else passed++;
                if (acked) begin
                    total++;
                    if ({wb_dest_reg, wb_data} !== {dest, exp_data}) begin
                        $display("FAIL rnd_mem_data_%0d: got d=%0d data=%h want %0d %h",
                                 n, wb_dest_reg, wb_data, dest, exp_data);
                    end else passed++;
                end
            end
        end
    endtask

    initial begin
        test_reset;
        test_alu;
        test_back_to_back;
        test_load;
        test_store;
        test_branch;
        test_timeout;
        test_reset_mid_access;
        test_random;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
